// File: rtl/nr_pkg.sv
// nr_pkg: shared types and constants for the
// noise-reduction stream filter.
package nr_pkg;

  typedef enum logic [1:0] {
    NR_BYPASS = 2'd0,
    NR_AVG2   = 2'd1,
    NR_IIR    = 2'd2
  } nr_mode_e;

  localparam int FRAME_CNT_W = 16;

  // Encoding 3 is reserved and behaves as bypass
  function automatic nr_mode_e nr_decode_mode(
    input logic [1:0] m
  );
    nr_mode_e r;
    case (m)
      2'd1:    r = NR_AVG2;
      2'd2:    r = NR_IIR;
      default: r = NR_BYPASS;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nr_skid_buf.sv
// nr_skid_buf: output register plus one-entry skid,
// with a registered ready derived from skid occupancy.
module nr_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ovld_q, ovld_d;
  logic         svld_q, svld_d;
  logic         rdy_q, rdy_d;
  logic         acc;

  assign acc = in_valid && rdy_q;

  always_comb begin
    out_d  = out_q;
    ovld_d = ovld_q;
    skid_d = skid_q;
    svld_d = svld_q;
    if (!ovld_q || out_ready) begin
      // Skid holds the older beat, so it drains first
      if (svld_q) begin
        out_d  = skid_q;
        ovld_d = 1'b1;
        svld_d = 1'b0;
      end else begin
        ovld_d = acc;
        if (acc) out_d = in_data;
      end
    end else if (acc) begin
      skid_d = in_data;
      svld_d = 1'b1;
    end
    rdy_d = !svld_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q  <= '0;
      ovld_q <= 1'b0;
      skid_q <= '0;
      svld_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      ovld_q <= ovld_d;
      skid_q <= skid_d;
      svld_q <= svld_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = out_q;
  assign out_valid = ovld_q;

endmodule

// File: rtl/nr_stream_filter.sv
// nr_stream_filter: per-channel horizontal smoothing
// with SOF regeneration and line-length checking.
module nr_stream_filter
  import nr_pkg::*;
#(
  parameter int CH_WIDTH = 10,
  parameter int CHANNELS = 4,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [CHANNELS*CH_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  input  logic                         in_user,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [CHANNELS*CH_WIDTH-1:0] out_data,
  output logic                         out_valid,
  output logic                         out_user,
  output logic                         out_last,
  input  logic                         out_ready,
  input  logic [1:0]                   mode,
  output logic                         err_short,
  output logic                         err_long,
  output logic [FRAME_CNT_W-1:0]       frame_cnt
);

  localparam int DW = CHANNELS * CH_WIDTH;
  localparam int PW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [PW-1:0] PIX_LAST  = PW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

  logic [PW-1:0]          pix_q, pix_d, pix_eff;
  logic [LW-1:0]          line_q, line_d, line_eff;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  nr_mode_e               mode_q, mode_d, mode_cur;
  logic                   es_q, es_d, el_q, el_d;
  logic                   accept, sof, pix_end;
  logic [DW-1:0]          filt;

  assign accept   = in_valid && in_ready;
  assign pix_eff  = in_user ? '0 : pix_q;
  assign line_eff = in_user ? '0 : line_q;
  assign sof      = (pix_eff == '0) && (line_eff == '0);
  assign pix_end  = (pix_eff == PIX_LAST);
  assign mode_cur = sof ? nr_decode_mode(mode) : mode_q;

  always_comb begin
    pix_d  = pix_q;
    line_d = line_q;
    fcnt_d = fcnt_q;
    mode_d = mode_q;
    es_d   = 1'b0;
    el_d   = 1'b0;
    if (accept) begin
      es_d   = in_last && !pix_end;
      el_d   = pix_end && !in_last;
      mode_d = mode_cur;
      // A full-length line without tlast still ends the line
      if (in_last || pix_end) begin
        pix_d = '0;
        if (line_eff == LINE_LAST) begin
          line_d = '0;
          fcnt_d = fcnt_q + 1'b1;
        end else begin
          line_d = line_eff + 1'b1;
        end
      end else begin
        pix_d = pix_eff + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_q  <= '0;
      line_q <= '0;
      fcnt_q <= '0;
      mode_q <= NR_BYPASS;
      es_q   <= 1'b0;
      el_q   <= 1'b0;
    end else begin
      pix_q  <= pix_d;
      line_q <= line_d;
      fcnt_q <= fcnt_d;
      mode_q <= mode_d;
      es_q   <= es_d;
      el_q   <= el_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [CH_WIDTH-1:0] x, y, prev_q;
    logic [CH_WIDTH:0]   s_avg;
    logic [CH_WIDTH+1:0] s_iir;

    assign x = in_data[c*CH_WIDTH +: CH_WIDTH];

    always_comb begin
      s_avg = {1'b0, x} + {1'b0, prev_q} + 1'b1;
      s_iir = {2'b0, prev_q} + {1'b0, prev_q, 1'b0}
            + {2'b0, x} + 2'd2;
      y = x;
      if (pix_eff != '0) begin
        unique case (mode_cur)
          NR_AVG2: y = s_avg[CH_WIDTH:1];
          NR_IIR:  y = s_iir[CH_WIDTH+1:2];
          default: y = x;
        endcase
      end
    end

    // IIR feeds back its output; the average needs the raw input
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) prev_q <= '0;
      else if (accept) prev_q <= (mode_cur == NR_IIR) ? y : x;
    end

    assign filt[c*CH_WIDTH +: CH_WIDTH] = y;
  end

  logic [DW+1:0] pkt_out;

  nr_skid_buf #(
    .W(DW + 2)
  ) u_skid (
    .clk      (clk),
    .rstn     (rstn),
    .in_data  ({sof, in_last, filt}),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (pkt_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_user  = pkt_out[DW+1];
  assign out_last  = pkt_out[DW];
  assign out_data  = pkt_out[DW-1:0];
  assign err_short = es_q;
  assign err_long  = el_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_nr_stream_filter.sv
// tb_nr_stream_filter: directed vector table plus
// randomised handshake run for nr_stream_filter.
module tb_nr_stream_filter;

  localparam int CW = 10;
  localparam int CH = 4;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int DW = CW * CH;

  logic          clk, rstn;
  logic [DW-1:0] in_data, out_data;
  logic          in_valid, in_user, in_last, in_ready;
  logic          out_valid, out_user, out_last, out_ready;
  logic [1:0]    mode;
  logic          err_short, err_long;
  logic [15:0]   frame_cnt;

  nr_stream_filter #(
    .CH_WIDTH(CW), .CHANNELS(CH),
    .H_ACTIVE(H), .V_ACTIVE(V)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_data(in_data), .in_valid(in_valid),
    .in_user(in_user), .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_user(out_user), .out_last(out_last),
    .out_ready(out_ready), .mode(mode),
    .err_short(err_short), .err_long(err_long),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } exp_t;

  typedef struct {
    logic [1:0] md;
    logic       u, l;
    logic [9:0] a, b, ea, eb;
    logic       eu;
    int         fc;
  } vec_t;

  int   nchk, nerr, occ, blocks;
  bit   rnd_en;
  exp_t q[$];
  exp_t me;
  vec_t tv[$];

  int m_pix, m_line, m_mode, m_frames;
  int m_prev[CH];

  function automatic logic [DW-1:0] pack2(
    input logic [9:0] a, input logic [9:0] b);
    return {b, a, b, a};
  endfunction

  task automatic chk(input string nm,
    input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pix = 0; m_line = 0; m_mode = 0; m_frames = 0;
    for (int c = 0; c < CH; c++) m_prev[c] = 0;
  endtask

  task automatic model_step(input logic [DW-1:0] d,
    input logic u, input logic l, input logic [1:0] md,
    output exp_t e);
    int p, ln, x, y;
    p  = u ? 0 : m_pix;
    ln = u ? 0 : m_line;
    e.u = (p == 0) && (ln == 0);
    e.l = l;
    if (e.u) m_mode = (md == 2'd1 || md == 2'd2) ? int'(md) : 0;
    for (int c = 0; c < CH; c++) begin
      x = int'(d[c*CW +: CW]);
      if (p == 0 || m_mode == 0) y = x;
      else if (m_mode == 1) y = (x + m_prev[c] + 1) / 2;
      else y = (3 * m_prev[c] + x + 2) / 4;
      m_prev[c] = (m_mode == 2) ? y : x;
      e.d[c*CW +: CW] = CW'(y);
    end
    if (l || p == H - 1) begin
      m_pix = 0;
      if (ln == V - 1) begin
        m_line = 0;
        m_frames++;
      end else begin
        m_line = ln + 1;
      end
    end else begin
      m_pix = p + 1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d,
    input logic u, input logic l, input logic [1:0] md,
    input bit hand, input exp_t he);
    exp_t e;
    int n;
    bit rdy;
    model_step(d, u, l, md, e);
    q.push_back(hand ? he : e);
    in_data = d; in_user = u; in_last = l;
    mode = md; in_valid = 1'b1; n = 0;
    forever begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 100) begin
        nchk++; nerr++;
        $display("FAIL accept_timeout: got no ready required ready");
        break;
      end
    end
    in_valid = 1'b0; in_user = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      nchk++; nerr++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size());
    end
  endtask

  task automatic add(input logic [1:0] md, input logic u,
    input logic l, input int a, input int b, input int ea,
    input int eb, input logic eu, input int fc);
    vec_t v;
    v.md = md; v.u = u; v.l = l;
    v.a = 10'(a); v.b = 10'(b);
    v.ea = 10'(ea); v.eb = 10'(eb);
    v.eu = eu; v.fc = fc;
    tv.push_back(v);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (occ == 2) begin
        blocks++;
        chk("skid_full_blocks_ready", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_beat: got %0h required none", out_data);
        end else begin
          me = q.pop_front();
          chk("out_data", 64'(out_data), 64'(me.d));
          chk("out_user", 64'(out_user), 64'(me.u));
          chk("out_last", 64'(out_last), 64'(me.l));
        end
      end
      occ = occ + int'(in_valid && in_ready)
                - int'(out_valid && out_ready);
    end
  end

  always begin
    @(posedge clk); #1;
    out_ready = rnd_en ? 1'($urandom % 2) : 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got hang required finish");
    $fatal(1);
  end

  initial begin
    exp_t he, dummy;
    logic [DW-1:0] d;
    logic [9:0] a, b;
    nchk = 0; nerr = 0; occ = 0; blocks = 0; rnd_en = 0;
    rstn = 1'b0; in_valid = 1'b0; in_user = 1'b0;
    in_last = 1'b0; in_data = '0; mode = 2'd0;
    out_ready = 1'b1;
    dummy.d = '0; dummy.u = 1'b0; dummy.l = 1'b0;
    model_reset();

    // T1 bypass: 3 frames of 4x2
    for (int i = 0; i < 24; i++) begin
      a = 10'((i * 41 + 3) % 1024);
      b = 10'((i * 97 + 5) % 1024);
      add(2'd0, i == 0, (i % 4) == 3, a, b, a, b,
          (i % 8) == 0, (i == 23) ? 3 : -1);
    end
    // T2 two-tap average
    add(2'd1, 0, 0, 100, 923, 100, 923, 1, -1);
    add(2'd1, 0, 0, 200, 823, 150, 873, 0, -1);
    add(2'd1, 0, 0, 301, 722, 251, 773, 0, -1);
    add(2'd1, 0, 1, 1023, 0, 662, 361, 0, -1);
    add(2'd1, 0, 0, 500, 523, 500, 523, 0, -1);
    add(2'd1, 0, 0, 10, 1013, 255, 768, 0, -1);
    add(2'd1, 0, 0, 20, 1003, 15, 1008, 0, -1);
    add(2'd1, 0, 1, 30, 993, 25, 998, 0, 4);
    // T3 IIR, mode dropped to 0 mid-frame
    add(2'd2, 0, 0, 0, 1023, 0, 1023, 1, -1);
    add(2'd2, 0, 0, 400, 623, 100, 923, 0, -1);
    add(2'd0, 0, 0, 400, 623, 175, 848, 0, -1);
    add(2'd0, 0, 1, 400, 623, 231, 792, 0, -1);
    add(2'd0, 0, 0, 800, 223, 800, 223, 0, -1);
    add(2'd0, 0, 0, 0, 1023, 600, 423, 0, -1);
    add(2'd0, 0, 0, 0, 1023, 450, 573, 0, -1);
    add(2'd0, 0, 1, 0, 1023, 338, 686, 0, 5);
    add(2'd0, 0, 0, 7, 1016, 7, 1016, 1, -1);
    add(2'd0, 0, 0, 9, 1014, 9, 1014, 0, -1);
    add(2'd0, 0, 0, 11, 1012, 11, 1012, 0, -1);
    add(2'd0, 0, 1, 13, 1010, 13, 1010, 0, -1);
    add(2'd0, 0, 0, 1, 1022, 1, 1022, 0, -1);
    add(2'd0, 0, 0, 2, 1021, 2, 1021, 0, -1);
    add(2'd0, 0, 0, 3, 1020, 3, 1020, 0, -1);
    add(2'd0, 0, 1, 4, 1019, 4, 1019, 0, 6);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_user", 64'(out_user), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < tv.size(); i++) begin
      he.d = pack2(tv[i].ea, tv[i].eb);
      he.u = tv[i].eu;
      he.l = tv[i].l;
      send(pack2(tv[i].a, tv[i].b), tv[i].u, tv[i].l,
           tv[i].md, 1'b1, he);
      if (tv[i].fc >= 0) begin
        wait_drain();
        chk("frame_cnt", 64'(frame_cnt), 64'(tv[i].fc));
      end
    end

    // T5 long line then short line
    for (int i = 0; i < 4; i++) begin
      send(pack2(10'(i + 50), 10'(i + 60)), 0, 0, 2'd0, 0, dummy);
      chk("err_long_beat", 64'(err_long), 64'(i == 3));
      chk("err_short_quiet", 64'(err_short), 64'd0);
    end
    send(pack2(10'd70, 10'd71), 0, 0, 2'd0, 0, dummy);
    chk("err_long_pulse_end", 64'(err_long), 64'd0);
    send(pack2(10'd72, 10'd73), 0, 0, 2'd0, 0, dummy);
    chk("err_short_early", 64'(err_short), 64'd0);
    send(pack2(10'd74, 10'd75), 0, 1, 2'd0, 0, dummy);
    chk("err_short_pulse", 64'(err_short), 64'd1);
    chk("err_long_quiet", 64'(err_long), 64'd0);
    @(posedge clk); #1;
    chk("err_short_pulse_end", 64'(err_short), 64'd0);
    wait_drain();
    chk("frame_cnt_t5", 64'(frame_cnt), 64'd7);

    // T4 random valid/ready
    rnd_en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if ($urandom % 2 == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      d[31:0] = $urandom;
      d[DW-1:32] = 8'($urandom);
      send(d, 0, m_pix == H - 1, 2'($urandom % 4), 0, dummy);
    end
    rnd_en = 1'b0;
    repeat (2) @(posedge clk);
    wait_drain();
    chk("frame_cnt_rand", 64'(frame_cnt), 64'(16'(m_frames)));
    chk("skid_full_seen", 64'(blocks > 0), 64'd1);

    // T6 reset mid-line
    send(pack2(10'd11, 10'd12), 0, 0, 2'd0, 0, dummy);
    send(pack2(10'd13, 10'd14), 0, 0, 2'd0, 0, dummy);
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    occ = 0;
    model_reset();
    rstn = 1'b1;
    @(posedge clk); #1;
    he.d = pack2(10'd321, 10'd654);
    he.u = 1'b1;
    he.l = 1'b0;
    send(pack2(10'd321, 10'd654), 0, 0, 2'd0, 1, he);
    wait_drain();
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
